// File: rtl/regfile_writer.sv
// regfile_writer: write-side sequencer for the 16x32 regfile.
// Queues (addr, data) requests and clears R0..NREGS-1 after reset or on request.
module regfile_writer #(
    parameter int DEPTH = 4,
    parameter int NREGS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_addr,
    input  logic [31:0] in_data,
    input  logic        clr_req,
    output logic [3:0]  wa3,
    output logic [31:0] wd3,
    output logic        we3,
    output logic        busy,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(NREGS + 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [35:0]   mem_q [DEPTH];

    logic          we3_q, we3_d;
    logic [3:0]    wa3_q, wa3_d;
    logic [31:0]   wd3_q, wd3_d;
    logic          err_q, err_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [35:0]   head;
    logic [3:0]    head_addr;
    logic [31:0]   head_data;
    logic          head_bad;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = (state_q == S_RUN) && !full;
    assign busy      = (state_q != S_RUN);
    assign push      = in_valid && in_ready;
    assign pop       = (state_q != S_CLEAR) && !empty;

    assign head      = mem_q[rptr_q];
    assign head_addr = head[35:32];
    assign head_data = head[31:0];
    // R15 (the PC) and anything past the cleared range is not writable.
    assign head_bad  = ({1'b0, head_addr} >= 5'(NREGS));

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;
    assign err = err_q;

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer: clear walk, normal run, and drain before a requested clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we3_d   = 1'b0;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        err_d   = err_q;

        unique case (state_q)
            S_CLEAR: begin
                if (cnt_q == CW'(NREGS)) begin
                    state_d = S_RUN;
                end else begin
                    we3_d = 1'b1;
                    wa3_d = 4'(cnt_q);
                    wd3_d = '0;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (clr_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase

        // Queue head goes to the write port; bad targets burn the slot.
        if (pop) begin
            wa3_d = head_addr;
            wd3_d = head_data;
            if (head_bad) begin
                err_d = 1'b1;
            end else begin
                we3_d = 1'b1;
            end
        end
    end

    // Control and write-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
            err_q   <= err_d;
        end
    end

    // FIFO storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {in_addr, in_data};
        end
    end

endmodule

// File: doc/regfile_writer.md
# regfile_writer

Write-side sequencer for the 16×32 `regfile`. It accepts (address, data) write requests on a valid/ready stream, buffers them in a small FIFO, and drives the regfile write port (`wa3`, `wd3`, `we3`) at one write per cycle. After every reset, and on request, it clears R0–R14 to zero, because `regfile` has no reset of its own. It sits between the processor's writeback/debug-load sources and `regfile`, and is the only driver of the regfile write port.

## Interface
Parameters:
- `DEPTH`, default 4: request FIFO entries (power of two, ≥2).
- `NREGS`, default 15: registers cleared/writable (R0..R14). R15 is the PC and is not writable.

Ports:
- `clk`  in  1: single clock, all state on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: write request present.
- `in_ready`  out  1: writer accepts a request this cycle.
- `in_addr`  in  4: target register.
- `in_data`  in  32: value to write.
- `clr_req`  in  1: one-cycle pulse requesting a full clear.
- `wa3`  out  4: regfile write address (registered).
- `wd3`  out  32: regfile write data (registered).
- `we3`  out  1: regfile write enable (registered).
- `busy`  out  1: high during CLEAR, and while a clear is pending.
- `err`  out  1: sticky flag, set when a request targets R15.

## Operation
- States: CLEAR, RUN, DRAIN.
- Reset (`reset`=0): state=CLEAR, clear counter=0, FIFO empty, `we3`=0, `wa3`=0, `wd3`=0, `in_ready`=0, `busy`=1, `err`=0. All outputs go to these values immediately (asynchronous reset).
- CLEAR:
  - Each edge issues `we3`=1, `wa3`=counter, `wd3`=0, then increments the counter.
  - After counter `NREGS`-1 is issued, the next edge sets `we3`=0, `busy`=0 and state=RUN.
  - `in_ready`=0 throughout CLEAR.
- RUN:
  - `in_ready` = FIFO not full.
  - A push happens on `in_valid && in_ready` at the edge.
  - If the FIFO is non-empty at an edge, the head is popped and registered onto `wa3`/`wd3` with `we3`=1. Otherwise `we3`=0 and `wa3`/`wd3` hold their previous values.
  - If the popped address is 15, `we3`=0 for that slot and `err` is set.
- Push while full: not accepted, even if a pop occurs on the same edge (`in_ready` is computed from the current count only).
- Simultaneous push and pop when not full: both occur, count is unchanged.
- `clr_req` in RUN:
  - `busy`=1 and `in_ready`=0 from the next cycle; state moves to DRAIN.
  - DRAIN pops the remaining entries normally. When the FIFO is empty, the next edge enters CLEAR with counter=0.
- `clr_req` during CLEAR or DRAIN is ignored.
- `err` clears only on reset.
- Ordering: writes reach the regfile in acceptance order. No entry is dropped except R15 targets.

## Timing
- Reset release to first clear write: the first rising edge with `reset`=1 drives `we3`=1, `wa3`=0.
- Clear sequence: `NREGS` consecutive `we3` cycles. RUN starts on edge `NREGS`+1 after release, with `in_ready`=1 in that cycle.
- Request latency:
  - A request accepted at edge N into an empty FIFO appears on `we3`/`wa3`/`wd3` from edge N+1.
  - The regfile captures it at edge N+2, and `rd` reflects it after N+2.
- Throughput: one write per cycle sustained.
- `in_ready` is combinational from state and count only. It has no path from `in_valid`.
- Reset mid-operation: the FIFO and any pending DRAIN/CLEAR are discarded, and `we3` falls asynchronously. A full clear restarts after release.

## Test plan
- Reset release: `we3`=1 for exactly 15 cycles with `wa3`=0..14 and `wd3`=0; then `busy`=0 and `in_ready`=1. Regfile reads of R0..R14 return 0x00000000.
- Single write (addr 2, 0x12345678) accepted at edge N: `we3`=1 and `wa3`=2 during cycle N+1. After N+2, regfile `ra1`=2 gives `rd1`=0x12345678, and R0 and R1 still read 0.
- Burst of 6 back-to-back requests (R3..R8, data 0xA0..0xA5) with `DEPTH`=4 and `in_valid` held: 6 consecutive `we3` cycles in order. All six registers read back correctly and no request is lost.
- Request to addr 15 (data 0xDEADBEEF) between writes to R4 (0x1) and R5 (0x2): no `we3` pulse in the R15 slot, and `err`=1 stays set. R4=0x1 and R5=0x2.
- `clr_req` with 3 entries queued (R1..R3 = 0x11, 0x22, 0x33): `in_ready` drops the next cycle and the 3 writes drain. Then 15 clear writes; `busy` is high from request until CLEAR ends, and afterwards R1..R3 read 0.
- `reset`=0 asserted mid-burst with 2 entries queued: `we3`=0 immediately and `err`=0. After release, a fresh 15-cycle clear runs and the queued entries never appear on the write port.
